// File: rtl/stream_comp_if.sv
// Handshake and result bundle for the word-serial magnitude comparator.
// The master drives the operand stream; the slave is the comparator.
interface stream_comp_if #(
    parameter int N = 4
) ();
    logic         start;
    logic         signed_mode;
    logic [N-1:0] a_word;
    logic [N-1:0] b_word;
    logic         in_valid;
    logic         in_ready;
    logic         busy;
    logic         done;
    logic         agb;
    logic         aeb;
    logic         alb;

    modport master (
        output start, signed_mode, a_word, b_word, in_valid,
        input  in_ready, busy, done, agb, aeb, alb
    );

    modport slave (
        input  start, signed_mode, a_word, b_word, in_valid,
        output in_ready, busy, done, agb, aeb, alb
    );
endinterface

// File: rtl/stream_comp.sv
// Word-serial magnitude comparator. Two N*K-bit operands arrive as K word
// pairs, most-significant word first. The first unequal pair fixes the
// outcome; the MSW may be compared as two's complement, every later word is
// compared unsigned. Result flags are registered and held between operations.
module stream_comp #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_comp_if.slave bus
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

    // Decision encoding: EQ also means "not yet decided".
    localparam logic [1:0] D_EQ = 2'b00;
    localparam logic [1:0] D_GT = 2'b01;
    localparam logic [1:0] D_LT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Compare one word pair; sgn selects two's-complement interpretation by
    // sign-extending both words one bit before a signed compare.
    function automatic logic [1:0] cmp_word(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic         sgn
    );
        logic signed [N:0] ax;
        logic signed [N:0] bx;
        ax = {sgn & a[N-1], a};
        bx = {sgn & b[N-1], b};
        if (ax > bx) begin
            cmp_word = D_GT;
        end else if (ax < bx) begin
            cmp_word = D_LT;
        end else begin
            cmp_word = D_EQ;
        end
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_dec;
    logic          r_sgn;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_agb;
    logic          r_aeb;
    logic          r_alb;

    logic [1:0]    w_cmp;
    logic [1:0]    w_final;
    logic          w_accept;

    // Compare the current pair; only the first accepted word may be signed.
    always_comb begin
        w_cmp = cmp_word(bus.a_word, bus.b_word, r_sgn & (r_cnt == CW'(0)));
    end

    // An earlier unequal pair wins; otherwise the current pair decides.
    always_comb begin
        w_final = D_EQ;
        if (r_dec != D_EQ) begin
            w_final = r_dec;
        end else begin
            w_final = w_cmp;
        end
    end

    // A pair is consumed only in RUN with both sides of the handshake high.
    always_comb begin
        w_accept = 1'b0;
        if (r_state == S_RUN) begin
            w_accept = bus.in_valid & r_in_ready;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Control FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= CW'(0);
            r_dec      <= D_EQ;
            r_sgn      <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_agb      <= 1'b0;
            r_aeb      <= 1'b0;
            r_alb      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state    <= S_RUN;
                        r_sgn      <= bus.signed_mode;
                        r_cnt      <= CW'(0);
                        r_dec      <= D_EQ;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_dec <= w_final;
                        if (r_cnt == LAST_IDX) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_agb      <= (w_final == D_GT);
                            r_aeb      <= (w_final == D_EQ);
                            r_alb      <= (w_final == D_LT);
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.agb      = r_agb;
    assign bus.aeb      = r_aeb;
    assign bus.alb      = r_alb;

endmodule

// File: tb/tb_stream_comp.sv
// Directed bench for stream_comp with N=4, K=2 (8-bit operands, MSW first).
module tb_stream_comp;
    logic clk;
    logic rst_n;

    stream_comp_if #(.N(4)) bus_if ();

    stream_comp #(.N(4), .K(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sgn;
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        logic [2:0] exp_flags;   // {agb, aeb, alb}
    } vec_t;

    vec_t tbl [9];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags();
        return {bus_if.agb, bus_if.aeb, bus_if.alb};
    endfunction

    // One full operation; a bogus pair is offered during the start cycle and
    // signed_mode is flipped after start, neither may affect the result.
    task automatic run_op(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input logic [2:0] exp_f, input string tag);
        logic [2:0] prev;
        prev = flags();
        bus_if.start       = 1'b1;
        bus_if.signed_mode = sgn;
        bus_if.in_valid    = 1'b1;
        bus_if.a_word      = 4'hF;
        bus_if.b_word      = 4'h0;
        chk({tag, "_idle_ready"}, {7'd0, bus_if.in_ready}, 8'd0);
        tick();
        bus_if.start       = 1'b0;
        bus_if.signed_mode = ~sgn;
        chk({tag, "_run_ready"}, {6'd0, bus_if.busy, bus_if.in_ready}, 8'h03);
        bus_if.a_word = a[7:4];
        bus_if.b_word = b[7:4];
        tick();
        for (int i = 0; i < stall; i++) begin
            bus_if.in_valid = 1'b0;
            bus_if.a_word   = 4'h0;
            bus_if.b_word   = 4'hF;
            tick();
            chk({tag, "_stall"}, {6'd0, bus_if.busy, bus_if.done}, 8'h02);
        end
        bus_if.in_valid = 1'b1;
        bus_if.a_word   = a[3:0];
        bus_if.b_word   = b[3:0];
        chk({tag, "_flags_hold"}, {5'd0, flags()}, {5'd0, prev});
        tick();
        bus_if.in_valid = 1'b0;
        chk({tag, "_done"}, {5'd0, bus_if.done, bus_if.busy, bus_if.in_ready}, 8'h06);
        chk({tag, "_flags"}, {5'd0, flags()}, {5'd0, exp_f});
        tick();
        chk({tag, "_idle"}, {6'd0, bus_if.done, bus_if.busy}, 8'h00);
        chk({tag, "_held"}, {5'd0, flags()}, {5'd0, exp_f});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        tbl[0] = '{1'b0, 8'b0011_1101, 8'b0011_1110, 0, 3'b001};
        tbl[1] = '{1'b0, 8'b1010_0000, 8'b1001_1111, 0, 3'b100};
        tbl[2] = '{1'b1, 8'b1010_0000, 8'b1001_1111, 0, 3'b100};
        tbl[3] = '{1'b1, 8'b1111_0001, 8'b0000_0110, 0, 3'b001};
        tbl[4] = '{1'b0, 8'b1111_0001, 8'b0000_0110, 0, 3'b100};
        tbl[5] = '{1'b0, 8'b0101_0101, 8'b0101_0101, 3, 3'b010};
        tbl[6] = '{1'b1, 8'b1000_1111, 8'b1000_0001, 0, 3'b100};
        tbl[7] = '{1'b1, 8'b0111_0000, 8'b1000_0000, 1, 3'b100};
        tbl[8] = '{1'b0, 8'b0111_0000, 8'b1000_0000, 0, 3'b001};

        rst_n              = 1'b0;
        bus_if.start       = 1'b1;
        bus_if.signed_mode = 1'b0;
        bus_if.in_valid    = 1'b1;
        bus_if.a_word      = 4'h0;
        bus_if.b_word      = 4'h0;
        tick();
        tick();
        chk("reset_outputs",
            {2'd0, bus_if.in_ready, bus_if.busy, bus_if.done, flags()}, 8'h00);
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
        rst_n           = 1'b1;
        tick();
        chk("post_reset_idle", {6'd0, bus_if.busy, bus_if.done}, 8'h00);

        for (int v = 0; v < 9; v++) begin
            run_op(tbl[v].sgn, tbl[v].a, tbl[v].b, tbl[v].stall, tbl[v].exp_flags,
                   $sformatf("vec%0d", v));
        end

        // Reset after the first accepted word abandons the operation.
        bus_if.start       = 1'b1;
        bus_if.signed_mode = 1'b0;
        tick();
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.a_word   = 4'h3;
        bus_if.b_word   = 4'h1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n           = 1'b1;
        chk("mid_reset_clear",
            {2'd0, bus_if.in_ready, bus_if.busy, bus_if.done, flags()}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_reset_no_done", {6'd0, bus_if.busy, bus_if.done}, 8'h00);
        end
        bus_if.in_valid = 1'b0;
        run_op(1'b0, 8'b0000_0001, 8'b0000_0000, 0, 3'b100, "after_reset");

        // start held through RUN and DONE must neither restart nor queue.
        bus_if.start       = 1'b1;
        bus_if.signed_mode = 1'b0;
        tick();
        bus_if.in_valid = 1'b1;
        bus_if.a_word   = 4'h2;
        bus_if.b_word   = 4'h5;
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        tick();
        chk("start_in_run_busy", {6'd0, bus_if.busy, bus_if.done}, 8'h02);
        bus_if.in_valid = 1'b1;
        bus_if.a_word   = 4'hF;
        bus_if.b_word   = 4'h0;
        tick();
        bus_if.in_valid = 1'b0;
        chk("start_in_run_done", {5'd0, bus_if.done, flags()}, 8'h09);
        tick();
        bus_if.start = 1'b0;
        chk("start_in_done_ignored", {6'd0, bus_if.busy, bus_if.done}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_queued_start", {5'd0, bus_if.in_ready, bus_if.busy, bus_if.done}, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
